ysyx_23060124_rf_wb_arbiter: RTL and testbench

- Owns the single write port of the integer register file and shares it between two writeback requesters: EXU (ALU/CSR results) and LSU (load data).
- Registers the granted write and drives wen/waddr/wdata into the register file.
- Keeps a per-register busy scoreboard so IDU can stall issue on RAW/WAW hazards.
- Sits between EXU/LSU writeback and the register file; IDU queries it every cycle.

---
 rtl/ysyx_23060124_rf_wb_arbiter_pkg.sv | 22 ++
 rtl/ysyx_23060124_rf_wb_arbiter_if.sv | 44 ++++
 rtl/ysyx_23060124_rf_scoreboard.sv | 44 ++++
 rtl/ysyx_23060124_rf_wb_arbiter.sv | 78 +++++++
 tb/tb_ysyx_23060124_rf_wb_arbiter.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060124_rf_wb_arbiter_pkg.sv
// Shared widths, requester encoding and writeback payload type for the
// register-file writeback arbiter.
package ysyx_23060124_rf_wb_arbiter_pkg;

  localparam int unsigned ISA_WIDTH = 32;
  localparam int unsigned REG_ADDR  = 5;
  localparam int unsigned REG_NUM   = 32;

  typedef logic [REG_ADDR-1:0]  reg_idx_t;
  typedef logic [ISA_WIDTH-1:0] word_t;

  typedef enum logic {
    REQ_EXU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

  typedef struct packed {
    reg_idx_t rd;
    word_t    data;
  } wb_req_t;

endpackage

// File: rtl/ysyx_23060124_rf_wb_arbiter_if.sv
// Writeback, issue-query and register-file write-port signals of the arbiter.
// master = pipeline/register-file side, slave = arbiter.
interface ysyx_23060124_rf_wb_arbiter_if;
  import ysyx_23060124_rf_wb_arbiter_pkg::*;

  logic     i_exu_valid;
  reg_idx_t i_exu_rd;
  word_t    i_exu_data;
  logic     o_exu_ready;

  logic     i_lsu_valid;
  reg_idx_t i_lsu_rd;
  word_t    i_lsu_data;
  logic     o_lsu_ready;

  logic     i_issue_valid;
  reg_idx_t i_issue_rd;
  logic     o_issue_ready;
  reg_idx_t i_raddr1;
  reg_idx_t i_raddr2;
  logic     o_hazard;
  logic     i_flush;

  logic     o_rf_wen;
  reg_idx_t o_rf_waddr;
  word_t    o_rf_wdata;

  modport slave (
    input  i_exu_valid, i_exu_rd, i_exu_data,
    input  i_lsu_valid, i_lsu_rd, i_lsu_data,
    input  i_issue_valid, i_issue_rd, i_raddr1, i_raddr2, i_flush,
    output o_exu_ready, o_lsu_ready, o_issue_ready, o_hazard,
    output o_rf_wen, o_rf_waddr, o_rf_wdata
  );

  modport master (
    output i_exu_valid, i_exu_rd, i_exu_data,
    output i_lsu_valid, i_lsu_rd, i_lsu_data,
    output i_issue_valid, i_issue_rd, i_raddr1, i_raddr2, i_flush,
    input  o_exu_ready, o_lsu_ready, o_issue_ready, o_hazard,
    input  o_rf_wen, o_rf_waddr, o_rf_wdata
  );

endinterface

// File: rtl/ysyx_23060124_rf_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared when the register file
// actually takes the write, wiped by flush. Index 0 is never busy.
module ysyx_23060124_rf_scoreboard
  import ysyx_23060124_rf_wb_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     i_rst,
  input  logic     i_issue_valid,
  input  reg_idx_t i_issue_rd,
  input  reg_idx_t i_raddr1,
  input  reg_idx_t i_raddr2,
  input  logic     i_flush,
  input  logic     i_clr_en,
  input  reg_idx_t i_clr_addr,
  output logic     o_issue_ready,
  output logic     o_hazard
);

  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;
  logic               set_en;

  assign o_issue_ready = ~busy_q[i_issue_rd];
  assign o_hazard      = busy_q[i_raddr1] | busy_q[i_raddr2];
  assign set_en        = i_issue_valid & o_issue_ready & (i_issue_rd != '0);

  // Flush wins over a same-cycle issue; WAW blocking keeps set/clear disjoint.
  always_comb begin
    busy_d = busy_q;
    if (i_flush) begin
      busy_d = '0;
    end else begin
      if (set_en)   busy_d[i_issue_rd] = 1'b1;
      if (i_clr_en) busy_d[i_clr_addr] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) busy_q <= '0;
    else       busy_q <= busy_d;
  end

endmodule

// File: rtl/ysyx_23060124_rf_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between
// EXU and LSU writeback, with a registered write stage and busy scoreboard.
module ysyx_23060124_rf_wb_arbiter
  import ysyx_23060124_rf_wb_arbiter_pkg::*;
(
  input  logic                             clk,
  input  logic                             i_rst,
  ysyx_23060124_rf_wb_arbiter_if.slave     bus
);

  req_e    ptr_q, ptr_d;
  logic    wen_q, wen_d;
  wb_req_t wr_q,  wr_d;
  logic    exu_gnt, lsu_gnt;

  assign bus.o_exu_ready = exu_gnt;
  assign bus.o_lsu_ready = lsu_gnt;
  assign bus.o_rf_wen    = wen_q;
  assign bus.o_rf_waddr  = wr_q.rd;
  assign bus.o_rf_wdata  = wr_q.data;

  // Pointer only advances after a contended grant; rd=0 is accepted but not written.
  always_comb begin
    ptr_d   = ptr_q;
    exu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    wen_d   = 1'b0;
    wr_d    = wr_q;

    if (bus.i_exu_valid && bus.i_lsu_valid) begin
      if (ptr_q == REQ_EXU) begin
        exu_gnt = 1'b1;
        ptr_d   = REQ_LSU;
      end else begin
        lsu_gnt = 1'b1;
        ptr_d   = REQ_EXU;
      end
    end else begin
      exu_gnt = bus.i_exu_valid;
      lsu_gnt = bus.i_lsu_valid;
    end

    if (exu_gnt) begin
      wr_d  = '{rd: bus.i_exu_rd, data: bus.i_exu_data};
      wen_d = (bus.i_exu_rd != '0);
    end else if (lsu_gnt) begin
      wr_d  = '{rd: bus.i_lsu_rd, data: bus.i_lsu_data};
      wen_d = (bus.i_lsu_rd != '0);
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= REQ_EXU;
      wen_q <= 1'b0;
      wr_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      wen_q <= wen_d;
      wr_q  <= wr_d;
    end
  end

  ysyx_23060124_rf_scoreboard u_scoreboard (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_issue_valid (bus.i_issue_valid),
    .i_issue_rd    (bus.i_issue_rd),
    .i_raddr1      (bus.i_raddr1),
    .i_raddr2      (bus.i_raddr2),
    .i_flush       (bus.i_flush),
    .i_clr_en      (wen_q),
    .i_clr_addr    (wr_q.rd),
    .o_issue_ready (bus.o_issue_ready),
    .o_hazard      (bus.o_hazard)
  );

endmodule

// File: tb/tb_ysyx_23060124_rf_wb_arbiter.sv
// Directed table-driven bench for the register-file writeback arbiter.
module tb_ysyx_23060124_rf_wb_arbiter;
  import ysyx_23060124_rf_wb_arbiter_pkg::*;

  logic clk;
  logic i_rst;
  int   n_checks;
  int   n_pass;

  ysyx_23060124_rf_wb_arbiter_if bus ();

  ysyx_23060124_rf_wb_arbiter dut (
    .clk   (clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic     ev;  reg_idx_t erd; word_t edat;
    logic     lv;  reg_idx_t lrd; word_t ldat;
    logic     iv;  reg_idx_t ird;
    reg_idx_t r1;  reg_idx_t r2;  logic  fl;
    logic     x_er; logic x_lr; logic x_ir; logic x_hz;
    logic     x_wen; reg_idx_t x_wa; word_t x_wd;
  } vec_t;

  localparam int unsigned NVEC = 21;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic ev, input reg_idx_t erd, input word_t edat,
    input logic lv, input reg_idx_t lrd, input word_t ldat,
    input logic iv, input reg_idx_t ird,
    input reg_idx_t r1, input reg_idx_t r2, input logic fl,
    input logic x_er, input logic x_lr, input logic x_ir, input logic x_hz,
    input logic x_wen, input reg_idx_t x_wa, input word_t x_wd);
    vec_t v;
    v.ev = ev; v.erd = erd; v.edat = edat;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat;
    v.iv = iv; v.ird = ird; v.r1 = r1; v.r2 = r2; v.fl = fl;
    v.x_er = x_er; v.x_lr = x_lr; v.x_ir = x_ir; v.x_hz = x_hz;
    v.x_wen = x_wen; v.x_wa = x_wa; v.x_wd = x_wd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input vec_t v);
    bus.i_exu_valid   = v.ev;  bus.i_exu_rd = v.erd; bus.i_exu_data = v.edat;
    bus.i_lsu_valid   = v.lv;  bus.i_lsu_rd = v.lrd; bus.i_lsu_data = v.ldat;
    bus.i_issue_valid = v.iv;  bus.i_issue_rd = v.ird;
    bus.i_raddr1      = v.r1;  bus.i_raddr2 = v.r2;  bus.i_flush = v.fl;
  endtask

  task automatic idle();
    drive(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    i_rst    = 1'b1;
    idle();

    //            ev erd    edat          lv lrd    ldat          iv ird    r1     r2     fl  er lr ir hz wen wa     wd
    vecs[0]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd5,  5'd5,  5'd0,  0,  0, 0, 1, 0, 0, 5'd0,  32'h0);
    vecs[1]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd5,  5'd5,  5'd0,  0,  0, 0, 0, 1, 0, 5'd0,  32'h0);
    vecs[2]  = mk(1, 5'd5,  32'h1234,     0, 5'd0,  32'h0,        0, 5'd5,  5'd5,  5'd0,  0,  1, 0, 0, 1, 0, 5'd0,  32'h0);
    vecs[3]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd5,  5'd5,  5'd0,  0,  0, 0, 0, 1, 1, 5'd5,  32'h1234);
    vecs[4]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd5,  5'd5,  5'd0,  0,  0, 0, 1, 0, 0, 5'd0,  32'h0);
    vecs[5]  = mk(1, 5'd3,  32'hA,        1, 5'd4,  32'hB,        0, 5'd0,  5'd3,  5'd4,  0,  1, 0, 1, 0, 0, 5'd0,  32'h0);
    vecs[6]  = mk(0, 5'd0,  32'h0,        1, 5'd4,  32'hB,        0, 5'd0,  5'd3,  5'd4,  0,  0, 1, 1, 0, 1, 5'd3,  32'hA);
    vecs[7]  = mk(1, 5'd10, 32'h10,       1, 5'd11, 32'h11,       0, 5'd0,  5'd0,  5'd0,  0,  0, 1, 1, 0, 1, 5'd4,  32'hB);
    vecs[8]  = mk(1, 5'd10, 32'h10,       0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd0,  0,  1, 0, 1, 0, 1, 5'd11, 32'h11);
    vecs[9]  = mk(0, 5'd0,  32'h0,        1, 5'd0,  32'hFFFF,     0, 5'd0,  5'd0,  5'd0,  0,  0, 1, 1, 0, 1, 5'd10, 32'h10);
    vecs[10] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd0,  0,  0, 0, 1, 0, 0, 5'd0,  32'h0);
    vecs[11] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd7,  5'd0,  5'd0,  0,  0, 0, 1, 0, 0, 5'd0,  32'h0);
    vecs[12] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd8,  5'd7,  5'd8,  1,  0, 0, 1, 1, 0, 5'd0,  32'h0);
    vecs[13] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd8,  5'd7,  5'd8,  0,  0, 0, 1, 0, 0, 5'd0,  32'h0);
    vecs[14] = mk(1, 5'd7,  32'h77,       0, 5'd0,  32'h0,        0, 5'd0,  5'd7,  5'd8,  0,  1, 0, 1, 0, 0, 5'd0,  32'h0);
    vecs[15] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  5'd7,  5'd8,  0,  0, 0, 1, 0, 1, 5'd7,  32'h77);
    vecs[16] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd9,  5'd0,  5'd0,  0,  0, 0, 1, 0, 0, 5'd0,  32'h0);
    vecs[17] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd9,  5'd9,  5'd0,  0,  0, 0, 0, 1, 0, 5'd0,  32'h0);
    vecs[18] = mk(1, 5'd9,  32'h99,       0, 5'd0,  32'h0,        1, 5'd9,  5'd9,  5'd0,  0,  1, 0, 0, 1, 0, 5'd0,  32'h0);
    vecs[19] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd9,  5'd9,  5'd0,  0,  0, 0, 0, 1, 1, 5'd9,  32'h99);
    vecs[20] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd9,  5'd9,  5'd0,  0,  0, 0, 1, 0, 0, 5'd0,  32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_wen",    32'(bus.o_rf_wen),      32'h0);
    chk("rst_waddr",  32'(bus.o_rf_waddr),    32'h0);
    chk("rst_wdata",  32'(bus.o_rf_wdata),    32'h0);
    chk("rst_iready", 32'(bus.o_issue_ready), 32'h1);
    chk("rst_hazard", 32'(bus.o_hazard),      32'h0);
    chk("rst_exu_rdy",32'(bus.o_exu_ready),   32'h0);
    i_rst = 1'b0;

    for (int i = 0; i < int'(NVEC); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_exu_ready", i), 32'(bus.o_exu_ready),   32'(vecs[i].x_er));
      chk($sformatf("v%0d_lsu_ready", i), 32'(bus.o_lsu_ready),   32'(vecs[i].x_lr));
      chk($sformatf("v%0d_iss_ready", i), 32'(bus.o_issue_ready), 32'(vecs[i].x_ir));
      chk($sformatf("v%0d_hazard",    i), 32'(bus.o_hazard),      32'(vecs[i].x_hz));
      chk($sformatf("v%0d_wen",       i), 32'(bus.o_rf_wen),      32'(vecs[i].x_wen));
      if (vecs[i].x_wen) begin
        chk($sformatf("v%0d_waddr", i), 32'(bus.o_rf_waddr), 32'(vecs[i].x_wa));
        chk($sformatf("v%0d_wdata", i), bus.o_rf_wdata,       vecs[i].x_wd);
      end
    end

    // Reset mid-write: contended EXU grant moves pointer to LSU, then reset.
    @(negedge clk);
    idle();
    bus.i_exu_valid = 1'b1; bus.i_exu_rd = 5'd12; bus.i_exu_data = 32'hC0DE;
    bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'd14; bus.i_lsu_data = 32'hBEEF;
    bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd13;
    #1;
    chk("mr_exu_ready", 32'(bus.o_exu_ready), 32'h1);
    chk("mr_lsu_ready", 32'(bus.o_lsu_ready), 32'h0);
    @(negedge clk);
    idle();
    bus.i_issue_rd = 5'd13; bus.i_raddr1 = 5'd13;
    #1;
    chk("mr_wen_before",    32'(bus.o_rf_wen),      32'h1);
    chk("mr_waddr_before",  32'(bus.o_rf_waddr),    32'd12);
    chk("mr_busy13_before", 32'(bus.o_issue_ready), 32'h0);
    i_rst = 1'b1;
    #1;
    chk("mr_wen_rst",    32'(bus.o_rf_wen),      32'h0);
    chk("mr_iready_rst", 32'(bus.o_issue_ready), 32'h1);
    chk("mr_hazard_rst", 32'(bus.o_hazard),      32'h0);
    @(negedge clk);
    i_rst = 1'b0;
    bus.i_exu_valid = 1'b1; bus.i_exu_rd = 5'd1; bus.i_exu_data = 32'h1;
    bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'd2; bus.i_lsu_data = 32'h2;
    #1;
    chk("post_rst_exu_ready", 32'(bus.o_exu_ready), 32'h1);
    chk("post_rst_lsu_ready", 32'(bus.o_lsu_ready), 32'h0);
    @(negedge clk);
    bus.i_exu_valid = 1'b0;
    #1;
    chk("post_rst_wen",   32'(bus.o_rf_wen),   32'h1);
    chk("post_rst_waddr", 32'(bus.o_rf_waddr), 32'd1);
    chk("post_rst_lsu",   32'(bus.o_lsu_ready), 32'h1);
    @(negedge clk);
    idle();
    #1;
    chk("post_rst_waddr2", 32'(bus.o_rf_waddr), 32'd2);
    chk("post_rst_wdata2", bus.o_rf_wdata,      32'h2);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
